// File: rtl/fp_sub_arbiter_pkg.sv
// fp_sub_pkg: shared types and helpers for the fpSub sharing arbiter.
//   FP_W        single-precision word width
//   fp32_t      raw IEEE-754 single-precision bit pattern
//   sub_tag_t   tag pipe entry {vld, id}, id wide enough for up to 8 requesters
//   fp_negate   pure sign flip (NaN/Inf/zero payloads untouched)
package fp_sub_pkg;

  localparam int FP_W = 32;

  typedef logic [FP_W-1:0] fp32_t;

  typedef struct packed {
    logic       vld;
    logic [2:0] id;
  } sub_tag_t;

  function automatic fp32_t fp_negate(input fp32_t x);
    return {~x[FP_W-1], x[FP_W-2:0]};
  endfunction

endpackage

// File: rtl/fp_sub_arbiter_if.sv
// fp_sub_arbiter_if: requester-side bus of the fpSub arbiter.
//   req_valid/req_ready  per-requester handshake (ready is a one-hot grant)
//   req_op               0 = a-b, 1 = a+b
//   req_a/req_b          operands, requester i in [32*i +: 32]
//   rsp_valid            one-cycle result pulse per requester
//   rsp_data             shared result word, qualified by rsp_valid
// master = requester side, slave = arbiter side.
interface fp_sub_arbiter_if #(
  parameter int N_REQ = 4
) ();
  import fp_sub_pkg::*;

  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ-1:0]      req_ready;
  logic [N_REQ-1:0]      req_op;
  logic [N_REQ*FP_W-1:0] req_a;
  logic [N_REQ*FP_W-1:0] req_b;
  logic [N_REQ-1:0]      rsp_valid;
  fp32_t                 rsp_data;

  modport master (
    output req_valid, req_op, req_a, req_b,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/fp_sub_arbiter_rr.sv
// rr_arbiter: combinational round-robin arbiter.
//   req      request vector
//   ptr      index of the last winner; search starts at ptr+1 and wraps
//   gnt      one-hot grant (all zero when nothing requests)
//   gnt_idx  binary index of the granted requester (0 when no grant)
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic          found;
  logic [IW-1:0] sel;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    sel     = '0;
    // k runs 1..N so the previous winner is examined last
    for (int unsigned k = 1; k <= N; k++) begin
      sel = IW'((32'(ptr) + k) % N);
      if (!found && req[sel]) begin
        found    = 1'b1;
        gnt[sel] = 1'b1;
        gnt_idx  = sel;
      end
    end
  end

endmodule

// File: rtl/fp_sub_arbiter.sv
// fp_sub_arbiter: shares one fixed-latency pipelined fpSub among N_REQ requesters.
//   aclk, aresetn        clock, asynchronous active-low reset
//   bus (slave)          requester handshake, operands and result pulses
//   sub_value1/2         registered operands to fpSub (value2 sign-flipped for add)
//   sub_result           fpSub output, valid SUB_LATENCY cycles after operands change
//   inflight, busy       accepted-but-unreturned count, and its non-zero flag
// One op is admitted per cycle via round-robin; a {vld,id} tag pipe of
// SUB_LATENCY+1 stages routes each result back to its issuer.
module fp_sub_arbiter
  import fp_sub_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int SUB_LATENCY = 8
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  fp_sub_arbiter_if.slave                  bus,
  output fp32_t                            sub_value1,
  output fp32_t                            sub_value2,
  input  fp32_t                            sub_result,
  output logic [$clog2(SUB_LATENCY+2)-1:0] inflight,
  output logic                             busy
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(SUB_LATENCY + 2);
  localparam int NS = SUB_LATENCY + 1;

  logic [IW-1:0]    ptr;
  logic [IW-1:0]    gnt_idx;
  logic [N_REQ-1:0] gnt;
  logic             hs;
  logic             ret;
  fp32_t            a_sel;
  fp32_t            b_sel;
  logic             op_sel;
  sub_tag_t         tag_q [NS];
  logic [N_REQ-1:0] rsp_valid_q;
  fp32_t            rsp_data_q;

  rr_arbiter #(
    .N  (N_REQ),
    .IW (IW)
  ) u_arb (
    .req     (bus.req_valid),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign bus.req_ready = gnt;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;

  // grant is only ever given to a valid requester, so any grant is a handshake
  assign hs   = |gnt;
  // last tag stage lines up with sub_result for the op issued SUB_LATENCY+1 edges ago
  assign ret  = tag_q[NS-1].vld;
  assign busy = (inflight != '0);

  always_comb begin
    a_sel  = '0;
    b_sel  = '0;
    op_sel = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        a_sel  = bus.req_a[i*FP_W +: FP_W];
        b_sel  = bus.req_b[i*FP_W +: FP_W];
        op_sel = bus.req_op[i];
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sub_value1  <= '0;
      sub_value2  <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      inflight    <= '0;
      ptr         <= IW'(N_REQ - 1);
      for (int unsigned s = 0; s < NS; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      if (hs) begin
        sub_value1 <= a_sel;
        sub_value2 <= op_sel ? fp_negate(b_sel) : b_sel;
        ptr        <= gnt_idx;
      end

      tag_q[0] <= '{vld: hs, id: 3'(gnt_idx)};
      for (int unsigned s = 1; s < NS; s++) begin
        tag_q[s] <= tag_q[s-1];
      end

      rsp_valid_q <= ret ? (N_REQ'(1) << tag_q[NS-1].id) : '0;
      if (ret) begin
        rsp_data_q <= sub_result;
      end

      case ({hs, ret})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_sub_arbiter.sv
// tb_fp_sub_arbiter: directed self-checking bench for fp_sub_arbiter with a
// behavioural fixed-latency fpSub model and an in-order response scoreboard.
module tb_fp_sub_arbiter;
  import fp_sub_pkg::*;

  localparam int N  = 4;
  localparam int L  = 8;
  localparam int CW = $clog2(L + 2);

  logic          aclk = 1'b0;
  logic          aresetn;
  fp32_t         sub_value1;
  fp32_t         sub_value2;
  fp32_t         sub_result;
  logic [CW-1:0] inflight;
  logic          busy;

  always #5 aclk = ~aclk;

  fp_sub_arbiter_if #(.N_REQ(N)) bus ();

  fp_sub_arbiter #(
    .N_REQ       (N),
    .SUB_LATENCY (L)
  ) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .bus        (bus),
    .sub_value1 (sub_value1),
    .sub_value2 (sub_value2),
    .sub_result (sub_result),
    .inflight   (inflight),
    .busy       (busy)
  );

  // float32 <-> real for normals, zeros, Inf/NaN (test values are exact)
  function automatic real f2r(input fp32_t f);
    logic [63:0] d;
    logic [10:0] e;
    if (f[30:23] == 8'h00)      d = {f[31], 63'b0};
    else if (f[30:23] == 8'hFF) d = {f[31], 11'h7FF, f[22:0], 29'b0};
    else begin
      e = 11'(f[30:23]) + 11'd896;
      d = {f[31], e, f[22:0], 29'b0};
    end
    return $bitstoreal(d);
  endfunction

  function automatic fp32_t r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:52] == 11'h000) return {d[63], 31'b0};
    if (d[62:52] == 11'h7FF) return {d[63], 8'hFF, d[51:29]};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic fp32_t model(input fp32_t a, input fp32_t b, input logic op);
    fp32_t bb;
    bb = op ? {~b[31], b[30:0]} : b;
    return r2f(f2r(a) - f2r(bb));
  endfunction

  // behavioural fpSub: result SUB_LATENCY edges after operands change
  fp32_t fpipe [L];
  always @(posedge aclk) begin
    fpipe[0] <= r2f(f2r(sub_value1) - f2r(sub_value2));
    for (int i = 1; i < L; i++) fpipe[i] <= fpipe[i-1];
  end
  assign sub_result = fpipe[L-1];

  typedef struct {
    int    id;
    fp32_t data;
    bit    chk_data;
  } exp_t;

  exp_t       sbq [$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         gnt_cyc [N];
  int         rsp_cyc [N];
  fp32_t      exp_data [N];
  bit         exp_chk [N];
  logic [N-1:0] oneshot;
  logic [N-1:0] last_gnt;
  int         peak;
  fp32_t      hold1, hold2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input fp32_t a, input fp32_t b, input logic op,
                         input fp32_t ed, input bit ec);
    bus.req_a[i*32 +: 32] = a;
    bus.req_b[i*32 +: 32] = b;
    bus.req_op[i]         = op;
    exp_data[i]           = ed;
    exp_chk[i]            = ec;
    bus.req_valid[i]      = 1'b1;
  endtask

  // one clock: record handshake at negedge, check responses after posedge
  task automatic tick();
    logic [N-1:0] hs;
    int           gi;
    exp_t         e;
    @(negedge aclk);
    last_gnt = bus.req_ready;
    chk("gnt_without_valid", 32'(bus.req_ready & ~bus.req_valid), 32'd0);
    chk("gnt_onehot", 32'($countones(bus.req_ready) <= 1), 32'd1);
    hs = bus.req_valid & bus.req_ready;
    gi = -1;
    for (int i = 0; i < N; i++) begin
      if (hs[i] && aresetn) begin
        gi = i;
        gnt_cyc[i] = cyc;
        e.id = i;
        e.data = exp_data[i];
        e.chk_data = exp_chk[i];
        sbq.push_back(e);
      end
    end
    @(posedge aclk);
    #1;
    cyc++;
    if (bus.rsp_valid != '0) begin
      if (sbq.size() == 0) begin
        chk("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("rsp_id", 32'(bus.rsp_valid), 32'(1) << e.id);
        if (e.chk_data) chk("rsp_data", bus.rsp_data, e.data);
        for (int i = 0; i < N; i++) if (bus.rsp_valid[i]) rsp_cyc[i] = cyc;
      end
    end
    chk("inflight", 32'(inflight), 32'(sbq.size()));
    chk("busy", 32'(busy), 32'(sbq.size() != 0));
    if (gi >= 0 && oneshot[gi]) bus.req_valid[gi] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 30) begin
      tick();
      n++;
    end
    chk("drain_timeout", 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn       = 1'b0;
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    oneshot       = '1;
    for (int i = 0; i < N; i++) begin
      gnt_cyc[i] = 0;
      rsp_cyc[i] = 0;
      exp_data[i] = '0;
      exp_chk[i] = 1'b0;
    end
    @(posedge aclk);
    @(posedge aclk);
    #1;
    chk("rst_sub_value1", sub_value1, 32'h0);
    chk("rst_sub_value2", sub_value2, 32'h0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_rsp_data", bus.rsp_data, 32'h0);
    chk("rst_inflight", 32'(inflight), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    aresetn = 1'b1;

    // single subtract, latency
    set_req(0, 32'h3FC00000, 32'h40200000, 1'b0, 32'hBF800000, 1'b1);
    tick();
    chk("t1_gnt", 32'(last_gnt), 32'h1);
    chk("t1_value1", sub_value1, 32'h3FC00000);
    chk("t1_value2", sub_value2, 32'h40200000);
    drain();
    chk("t1_latency", 32'(rsp_cyc[0] - gnt_cyc[0]), 32'd10);

    // two requesters in the same cycle
    set_req(1, 32'hBFC00000, 32'h3FC00000, 1'b0, 32'hC0400000, 1'b1);
    set_req(2, 32'h3FC00000, 32'h40200000, 1'b1, 32'h40800000, 1'b1);
    tick();
    chk("t2_gnt_first", 32'(last_gnt), 32'h2);
    tick();
    chk("t2_gnt_second", 32'(last_gnt), 32'h4);
    drain();
    chk("t2_rsp_consecutive", 32'(rsp_cyc[2] - rsp_cyc[1]), 32'd1);

    // exact zero, NaN add sign flip
    set_req(3, 32'h3F800000, 32'h3F800000, 1'b0, 32'h00000000, 1'b1);
    tick();
    chk("t3_gnt", 32'(last_gnt), 32'h8);
    set_req(0, 32'h3F800000, 32'h7FC00000, 1'b1, 32'h0, 1'b0);
    tick();
    chk("t3_gnt_nan", 32'(last_gnt), 32'h1);
    chk("t3_nan_value1", sub_value1, 32'h3F800000);
    chk("t3_nan_value2", sub_value2, 32'hFFC00000);
    drain();

    // reset with operations in flight
    set_req(0, 32'h3F800000, 32'h3F000000, 1'b0, 32'h3F000000, 1'b1);
    set_req(1, 32'h40000000, 32'h3F000000, 1'b0, 32'h3FC00000, 1'b1);
    set_req(2, 32'h40400000, 32'h3F000000, 1'b0, 32'h40200000, 1'b1);
    tick();
    tick();
    tick();
    chk("t4_inflight_before", 32'(inflight), 32'd3);
    aresetn = 1'b0;
    bus.req_valid = '0;
    sbq.delete();
    #1;
    chk("t4_async_inflight", 32'(inflight), 32'd0);
    tick();
    tick();
    aresetn = 1'b1;
    for (int k = 0; k < 12; k++) tick();

    // all requesters continuously valid
    oneshot = '0;
    peak = 0;
    for (int i = 0; i < N; i++) begin
      fp32_t a;
      logic  op;
      a  = r2f(real'(i + 1));
      op = (i == 3);
      set_req(i, a, 32'h3F000000, op, model(a, 32'h3F000000, op), 1'b1);
    end
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("t5_rotate", 32'(last_gnt), 32'(1) << (k % N));
      if (int'(inflight) > peak) peak = int'(inflight);
    end
    bus.req_valid = '0;
    oneshot = '1;
    drain();
    chk("t5_peak_inflight", 32'(peak), 32'd9);

    // idle
    hold1 = sub_value1;
    hold2 = sub_value2;
    for (int k = 0; k < 15; k++) begin
      tick();
      chk("t6_value1_stable", sub_value1, hold1);
      chk("t6_value2_stable", sub_value2, hold2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
